// File: rtl/hamming_secded_codec.sv
// rtl/hamming_secded_codec.sv - parametrised SECDED Hamming encoder/decoder, 2-stage valid/ready pipeline
// Stage 1 encodes or computes syndrome/parity; stage 2 corrects, extracts data and drives the output.
module hamming_secded_codec #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16,
    localparam int PAR_W = (DATA_W <= 4) ? 3 : (DATA_W <= 11) ? 4 : (DATA_W <= 26) ? 5 : 6,
    localparam int CW_W  = DATA_W + PAR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [CW_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW_W-1:0]  out_data,
    output logic [1:0]       out_err,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] corr_cnt,
    output logic [CNT_W-1:0] uncorr_cnt
);

    localparam logic [PAR_W:0] CW_LIM = CW_W[PAR_W:0];

    logic             adv1;
    logic             adv2;
    logic             s1_valid;
    logic             s1_mode;
    logic             s1_par;
    logic [CW_W-1:0]  s1_word;
    logic [PAR_W-1:0] s1_syn;
    logic [CW_W-1:0]  enc_word;
    logic [PAR_W-1:0] in_syn;
    logic [CW_W-1:0]  fix_word;
    logic [DATA_W-1:0] fix_data;
    logic [1:0]       fix_err;

    assign adv2     = !out_valid || out_ready;
    assign adv1     = !s1_valid || adv2;
    assign in_ready = adv1;

    // Data fills non-power-of-two positions; parity at 2^j is computed after placement.
    always_comb begin : enc_comb
        int   di;
        logic p;
        di       = 0;
        p        = 1'b0;
        enc_word = '0;
        for (int k = 1; k < CW_W; k++) begin
            if ((k & (k - 1)) != 0) begin
                enc_word[k] = in_data[di];
                di++;
            end
        end
        for (int j = 0; j < PAR_W; j++) begin
            p = 1'b0;
            for (int k = 1; k < CW_W; k++) begin
                if (((k >> j) & 1) != 0) p ^= enc_word[k];
            end
            enc_word[1 << j] = p;
        end
        enc_word[0] = ^enc_word[CW_W-1:1];
    end

    always_comb begin : syn_comb
        in_syn = '0;
        for (int k = 1; k < CW_W; k++) begin
            if (in_data[k]) in_syn ^= PAR_W'(k);
        end
    end

    // Syndrome 0 with odd parity points at the overall parity bit itself.
    always_comb begin : fix_comb
        int   di;
        logic flip;
        di       = 0;
        flip     = s1_par && ({1'b0, s1_syn} < CW_LIM);
        fix_word = flip ? (s1_word ^ (CW_W'(1) << s1_syn)) : s1_word;
        if (!s1_par && s1_syn == '0)
            fix_err = 2'b00;
        else if (flip)
            fix_err = 2'b01;
        else
            fix_err = 2'b10;
        fix_data = '0;
        for (int k = 1; k < CW_W; k++) begin
            if ((k & (k - 1)) != 0) begin
                fix_data[di] = fix_word[k];
                di++;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_mode  <= 1'b0;
            s1_word  <= '0;
            s1_syn   <= '0;
            s1_par   <= 1'b0;
        end else if (adv1) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_mode <= in_mode;
                s1_word <= in_mode ? in_data : enc_word;
                s1_syn  <= in_syn;
                s1_par  <= ^in_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_err   <= 2'b00;
        end else if (adv2) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= s1_mode ? {{(CW_W-DATA_W){1'b0}}, fix_data} : s1_word;
                out_err  <= s1_mode ? fix_err : 2'b00;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else if (cnt_clr) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else if (out_valid && out_ready) begin
            if (out_err == 2'b01 && corr_cnt != '1)
                corr_cnt <= corr_cnt + CNT_W'(1);
            if (out_err == 2'b10 && uncorr_cnt != '1)
                uncorr_cnt <= uncorr_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hamming_secded_codec.sv
// tb/tb_hamming_secded_codec.sv - scoreboard bench for hamming_secded_codec with DATA_W=8
// Counters are built 8 bits wide so saturation is reachable in a short run.
module tb_hamming_secded_codec;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_mode = 1'b0;
    logic [12:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [12:0] out_data;
    logic [1:0]  out_err;
    logic        cnt_clr = 1'b0;
    logic [7:0]  corr_cnt;
    logic [7:0]  uncorr_cnt;

    int          checks = 0;
    int          errors = 0;
    logic [14:0] exp_q[$];
    logic [14:0] exp_w;
    int          m_corr = 0;
    int          m_uncorr = 0;
    int          data_pos [8] = '{3, 5, 6, 7, 9, 10, 11, 12};

    hamming_secded_codec #(.DATA_W(8), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err),
        .cnt_clr(cnt_clr), .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Parity bits are chosen so the XOR of set-bit indices of the whole word is zero.
    function automatic logic [12:0] m_encode(input logic [7:0] d);
        logic [12:0] cw = '0;
        logic [3:0]  s = '0;
        for (int i = 0; i < 8; i++) begin
            cw[data_pos[i]] = d[i];
            if (d[i]) s ^= 4'(data_pos[i]);
        end
        cw[1] = s[0];
        cw[2] = s[1];
        cw[4] = s[2];
        cw[8] = s[3];
        cw[0] = ^cw[12:1];
        return cw;
    endfunction

    function automatic logic [14:0] m_expect(input logic md, input logic [12:0] w);
        logic [3:0]  s = '0;
        logic        p;
        logic [12:0] f;
        logic [7:0]  d;
        logic [1:0]  e;
        if (!md) return {m_encode(w[7:0]), 2'b00};
        for (int k = 1; k < 13; k++)
            if (w[k]) s ^= 4'(k);
        p = ^w;
        f = w;
        if (!p && s == 4'd0) e = 2'b00;
        else if (p && s < 4'd13) begin
            f[s] = ~f[s];
            e = 2'b01;
        end else e = 2'b10;
        for (int i = 0; i < 8; i++) d[i] = f[data_pos[i]];
        return {5'b0, d, e};
    endfunction

    task automatic gen(output logic md, output logic [12:0] w);
        logic [12:0] cw;
        int a;
        int b;
        md = 1'($urandom_range(0, 1));
        if (!md) w = 13'($urandom);
        else begin
            cw = m_encode(8'($urandom));
            case ($urandom_range(0, 3))
                0: w = cw;
                1: begin
                    a = $urandom_range(0, 12);
                    cw[a] = ~cw[a];
                    w = cw;
                end
                2: begin
                    a = $urandom_range(0, 12);
                    b = (a + $urandom_range(1, 12)) % 13;
                    cw[a] = ~cw[a];
                    cw[b] = ~cw[b];
                    w = cw;
                end
                default: w = 13'($urandom);
            endcase
        end
    endtask

    task automatic send(input logic md, input logic [12:0] wd, input logic [12:0] ed,
                        input logic [1:0] ee, output int waited);
        waited = 0;
        in_valid = 1'b1;
        in_mode = md;
        in_data = wd;
        #1;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            #1;
            waited++;
        end
        check("send_accept", in_ready, 1);
        if (in_ready) exp_q.push_back({ed, ee});
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            #3;
            n++;
        end
        check("drain_left", exp_q.size(), 0);
        @(negedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        #2;
        if (rst_n) begin
            check("corr_cnt", corr_cnt, m_corr);
            check("uncorr_cnt", uncorr_cnt, m_uncorr);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got data 0x%0h with no word outstanding", out_data);
                end else begin
                    exp_w = exp_q.pop_front();
                    check("out_data", out_data, exp_w[14:2]);
                    check("out_err", out_err, exp_w[1:0]);
                    if (exp_w[1:0] == 2'b01 && m_corr < 255) m_corr++;
                    if (exp_w[1:0] == 2'b10 && m_uncorr < 255) m_uncorr++;
                end
            end
            if (cnt_clr) begin
                m_corr = 0;
                m_uncorr = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        int          w;
        int          acc;
        logic        md;
        logic [12:0] wd;
        logic [14:0] ex;
        logic [7:0]  dd;

        repeat (3) @(negedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_err", out_err, 0);
        check("rst_corr", corr_cnt, 0);
        check("rst_uncorr", uncorr_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 1);
        @(negedge clk);
        out_ready = 1'b1;

        send(1'b0, 13'h00A5, 13'h144E, 2'b00, w);
        #1;
        check("latency_early", out_valid, 0);
        @(negedge clk);
        #1;
        check("latency_valid", out_valid, 1);

        send(1'b0, 13'h1F00, 13'h0000, 2'b00, w);
        send(1'b1, 13'h144E, 13'h00A5, 2'b00, w);
        send(1'b1, 13'h140E, 13'h00A5, 2'b01, w);
        send(1'b1, 13'h144F, 13'h00A5, 2'b01, w);
        send(1'b1, 13'h140F, 13'h00A1, 2'b10, w);
        send(1'b1, 13'h0448, 13'h0025, 2'b10, w);
        drain();
        check("directed_corr", corr_cnt, 2);
        check("directed_uncorr", uncorr_cnt, 2);

        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            md = i[0];
            wd = md ? (m_encode(8'($urandom)) ^ (13'd1 << $urandom_range(0, 12))) : 13'($urandom);
            ex = m_expect(md, wd);
            send(md, wd, ex[14:2], ex[1:0], w);
            check("throughput_wait", w, 0);
        end
        drain();

        @(negedge clk);
        out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            gen(md, wd);
            in_valid = 1'b1;
            in_mode = md;
            in_data = wd;
            #1;
            if (in_ready) begin
                acc++;
                exp_q.push_back(m_expect(md, wd));
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("bp_accepts", acc, 2);
        #1;
        check("bp_in_ready", in_ready, 0);
        out_ready = 1'b1;
        drain();

        @(negedge clk);
        for (int i = 0; i < 260; i++) begin
            dd = 8'($urandom);
            wd = m_encode(dd) ^ (13'd1 << $urandom_range(0, 12));
            send(1'b1, wd, {5'b0, dd}, 2'b01, w);
        end
        drain();
        check("corr_saturated", corr_cnt, 8'hFF);

        @(negedge clk);
        out_ready = 1'b0;
        send(1'b1, m_encode(8'h3C) ^ 13'h0010, 13'h003C, 2'b01, w);
        @(negedge clk);
        #1;
        check("clr_out_valid", out_valid, 1);
        @(negedge clk);
        out_ready = 1'b1;
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        #1;
        check("clr_corr", corr_cnt, 0);
        check("clr_uncorr", uncorr_cnt, 0);
        drain();

        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            out_ready = ($urandom_range(0, 3) != 0);
            cnt_clr = ($urandom_range(0, 63) == 0);
            in_valid = ($urandom_range(0, 2) != 0);
            gen(md, wd);
            in_mode = md;
            in_data = wd;
            #1;
            if (in_valid && in_ready) exp_q.push_back(m_expect(md, wd));
        end
        @(negedge clk);
        in_valid = 1'b0;
        cnt_clr = 1'b0;
        out_ready = 1'b1;
        drain();

        @(negedge clk);
        out_ready = 1'b0;
        send(1'b1, 13'h140E, 13'h00A5, 2'b01, w);
        send(1'b1, 13'h140F, 13'h00A1, 2'b10, w);
        #1;
        check("full_in_ready", in_ready, 0);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        m_corr = 0;
        m_uncorr = 0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_corr", corr_cnt, 0);
        check("midrst_uncorr", uncorr_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midrst_in_ready", in_ready, 1);
        check("midrst_valid_after", out_valid, 0);
        out_ready = 1'b1;
        @(negedge clk);
        send(1'b0, 13'h00A5, 13'h144E, 2'b00, w);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
